// File: rtl/mux_sum_accumulator_pkg.sv
// Shared state encodings and default widths for the mux sum accumulator.
package mux_sum_accumulator_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int unsigned DEF_DATA_W  = 2;
  localparam int unsigned DEF_ACC_W   = 8;
  localparam int unsigned DEF_COUNT_N = 8;

endpackage

// File: rtl/mux_sum_accumulator_rca_adder.sv
// Ripple-carry adder built from a chain of full adders.
module rca_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[W];

endmodule

// File: rtl/mux_sum_accumulator.sv
// Frames COUNT_N accepted mux samples into a wrapping running sum with sticky
// carry-out flag; DONE pulses once per completed frame.
module mux_sum_accumulator
  import mux_sum_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned COUNT_N = DEF_COUNT_N
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [DATA_W-1:0]                d_i,
  output logic [ACC_W-1:0]                 sum_o,
  output logic                             ovf_o,
  output logic [$clog2(COUNT_N+1)-1:0]     cnt_o,
  output logic                             done_o
);

  localparam int unsigned CNT_W = $clog2(COUNT_N + 1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ready_q;

  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;

  rca_adder #(.W(ACC_W)) u_add (
    .a_i    (sum_q),
    .b_i    (ACC_W'(d_i)),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign xfer    = in_valid_i & ready_q;
  assign cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

  // Next-state: START always wins and discards any concurrent sample.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (start_i) begin
          sum_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (start_i) begin
          sum_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end else if (xfer) begin
          sum_d = add_sum;
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(COUNT_N)) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ready_q <= (state_d == ST_ACCUM);
    end
  end

  assign in_ready_o = ready_q;
  assign sum_o      = sum_q;
  assign ovf_o      = ovf_q;
  assign cnt_o      = cnt_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_mux_sum_accumulator.sv
// Directed bench for mux_sum_accumulator: 8-bit and 4-bit accumulator instances share stimulus.
module tb_mux_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [1:0] d;

  logic       rdy8, ovf8, done8;
  logic [7:0] sum8;
  logic [3:0] cnt8;
  logic       rdy4, ovf4, done4;
  logic [3:0] sum4;
  logic [3:0] cnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_sum_accumulator #(.DATA_W(2), .ACC_W(8), .COUNT_N(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(rdy8), .d_i(d), .sum_o(sum8), .ovf_o(ovf8),
    .cnt_o(cnt8), .done_o(done8)
  );

  mux_sum_accumulator #(.DATA_W(2), .ACC_W(4), .COUNT_N(8)) dut4 (
    .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(rdy4), .d_i(d), .sum_o(sum4), .ovf_o(ovf4),
    .cnt_o(cnt4), .done_o(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int s, input int c, input bit o,
                      input bit dn, input bit r);
    chk({tag, ".sum"},   32'(sum8),  32'(s));
    chk({tag, ".cnt"},   32'(cnt8),  32'(c));
    chk({tag, ".ovf"},   32'(ovf8),  32'(o));
    chk({tag, ".done"},  32'(done8), 32'(dn));
    chk({tag, ".ready"}, 32'(rdy8),  32'(r));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; d = 2'd0;
    tick(); tick();
    rst = 1'b0;
    chk8("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset4.sum", 32'(sum4), 32'd0);

    // Idle with a valid sample: ignored.
    in_valid = 1'b1; d = 2'd3;
    tick();
    chk8("idle_valid", 0, 0, 1'b0, 1'b0, 1'b0);

    // Full frame of D=3.
    start = 1'b1; in_valid = 1'b0;
    tick();
    chk8("start", 0, 0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; in_valid = 1'b1; d = 2'd3;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("frame.sum", 32'(sum8), 32'(3 * k));
      chk("frame.cnt", 32'(cnt8), 32'(k));
      chk("frame.done", 32'(done8), 32'(k == 8));
      chk("frame.ready", 32'(rdy8), 32'(k != 8));
    end
    chk("frame.ovf", 32'(ovf8), 32'd0);
    chk("frame4.sum", 32'(sum4), 32'd8);
    chk("frame4.ovf", 32'(ovf4), 32'd1);
    chk("frame4.done", 32'(done4), 32'd1);

    // Hold: valid samples ignored, DONE drops.
    tick();
    chk8("hold", 24, 8, 1'b0, 1'b0, 1'b0);
    chk("hold4.sum", 32'(sum4), 32'd8);
    chk("hold4.ovf", 32'(ovf4), 32'd1);
    tick();
    chk8("hold2", 24, 8, 1'b0, 1'b0, 1'b0);

    // Restart from hold clears sticky overflow.
    start = 1'b1; in_valid = 1'b0;
    tick();
    chk8("restart", 0, 0, 1'b0, 1'b0, 1'b1);
    chk("restart4.sum", 32'(sum4), 32'd0);
    chk("restart4.ovf", 32'(ovf4), 32'd0);
    start = 1'b0;

    // Valid gaps with X on D when not valid.
    in_valid = 1'b1; d = 2'd1;  tick();
    in_valid = 1'b0; d = 2'bxx; tick();
    chk8("gap1", 1, 1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1; d = 2'd2;  tick();
    in_valid = 1'b0; d = 2'bxx; tick();
    in_valid = 1'b1; d = 2'd3;  tick();
    in_valid = 1'b1; d = 2'd1;  tick();
    chk8("gaps", 7, 4, 1'b0, 1'b0, 1'b1);

    // START mid-frame after three D=2 samples.
    start = 1'b1; in_valid = 1'b1; d = 2'd3;
    tick();
    chk8("mid_clear", 0, 0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; d = 2'd2;
    tick(); tick(); tick();
    chk8("three_twos", 6, 3, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    chk8("mid_restart", 0, 0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; d = 2'd1;
    tick();
    chk8("after_restart", 1, 1, 1'b0, 1'b0, 1'b1);
    d = 2'd3;
    tick();
    chk8("pre_rst", 4, 2, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk8("async_rst", 0, 0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    chk8("rst_held", 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b1; d = 2'd3;
    tick();
    chk8("post_rst_idle", 0, 0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
